// File: rtl/perf_pkg.sv
// Shared types and helpers for the performance counter bank.
package perf_pkg;

  typedef enum logic {PERF_IDLE, PERF_DUMP} perf_state_t;

  // Upper bounds for the slice-extraction helper.
  localparam int unsigned PERF_MAX_VEC_W = 1024;
  localparam int unsigned PERF_MAX_INC_W = 16;

  // Extract the w-bit increment of channel idx from a packed increment vector.
  function automatic logic [PERF_MAX_INC_W-1:0] perf_inc_slice(
    input logic [PERF_MAX_VEC_W-1:0] vec,
    input int unsigned               idx,
    input int unsigned               w
  );
    logic [PERF_MAX_VEC_W-1:0] shifted;
    logic [PERF_MAX_INC_W-1:0] mask;
    shifted = vec >> (idx * w);
    mask    = ~({PERF_MAX_INC_W{1'b1}} << w);
    return PERF_MAX_INC_W'(shifted) & mask;
  endfunction

endpackage

// File: rtl/perf_counter_slice.sv
// One counter channel: live count with sticky overflow plus a snapshot shadow copy.
module perf_counter_slice #(
  parameter int unsigned CNT_WIDTH = 48,
  parameter int unsigned INC_WIDTH = 3,
  parameter int unsigned SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [INC_WIDTH-1:0] inc,
  input  logic                 clear,
  input  logic                 capture,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 ovf,
  output logic [CNT_WIDTH-1:0] shadow,
  output logic                 sovf,
  output logic                 ovf_next_c
);

  localparam int unsigned SUM_W = CNT_WIDTH + 1;

  logic [SUM_W-1:0]     sum_c;
  logic                 carry_c;
  logic [CNT_WIDTH-1:0] cnt_next_c;

  // Next count: clear wins over increment; carry-out marks overflow.
  always_comb begin
    sum_c      = SUM_W'(cnt) + SUM_W'(inc);
    carry_c    = sum_c[CNT_WIDTH];
    cnt_next_c = cnt;
    ovf_next_c = ovf;
    if (clear) begin
      cnt_next_c = '0;
      ovf_next_c = 1'b0;
    end else if (en) begin
      if (carry_c) begin
        ovf_next_c = 1'b1;
        cnt_next_c = (SATURATE != 0) ? {CNT_WIDTH{1'b1}} : sum_c[CNT_WIDTH-1:0];
      end else begin
        cnt_next_c = sum_c[CNT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_next_c;
      ovf <= ovf_next_c;
    end
  end

  // Shadow takes the pre-update live value so snapshot plus clear is atomic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      sovf   <= 1'b0;
    end else if (capture) begin
      shadow <= cnt;
      sovf   <= ovf;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters with sticky overflow, global enable/clear and a
// snapshot that is streamed out one channel per beat over valid/ready.
module perf_counter_bank #(
  parameter int unsigned NUM_EVENTS = 16,
  parameter int unsigned CNT_WIDTH  = 48,
  parameter int unsigned INC_WIDTH  = 3,
  parameter int unsigned SATURATE   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cnt_en,
  input  logic [NUM_EVENTS*INC_WIDTH-1:0]  event_inc,
  input  logic                             clear,
  input  logic                             snap_req,
  output logic                             snap_busy,
  output logic                             dump_valid,
  input  logic                             dump_ready,
  output logic [$clog2(NUM_EVENTS)-1:0]    dump_idx,
  output logic [CNT_WIDTH-1:0]             dump_data,
  output logic                             dump_ovf,
  output logic                             dump_last,
  output logic                             ovf_any
);
  import perf_pkg::*;

  localparam int unsigned PERF_IDX_W = $clog2(NUM_EVENTS);
  localparam logic [PERF_IDX_W-1:0] LAST_IDX = PERF_IDX_W'(NUM_EVENTS - 1);

  perf_state_t state_q, state_d;

  logic [PERF_MAX_VEC_W-1:0] inc_vec_c;
  logic [CNT_WIDTH-1:0]      cnt    [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]      shadow [NUM_EVENTS];
  logic [NUM_EVENTS-1:0]     ovf;
  logic [NUM_EVENTS-1:0]     sovf;
  logic [NUM_EVENTS-1:0]     ovf_next;

  logic                      capture_c;
  logic [PERF_IDX_W-1:0]     idx_next_c;
  logic [PERF_IDX_W-1:0]     idx_d;
  logic [CNT_WIDTH-1:0]      data_d;
  logic                      dovf_d;
  logic                      last_d;
  logic                      valid_d;

  assign inc_vec_c = PERF_MAX_VEC_W'(event_inc);

  for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_ch
    perf_counter_slice #(
      .CNT_WIDTH (CNT_WIDTH),
      .INC_WIDTH (INC_WIDTH),
      .SATURATE  (SATURATE)
    ) u_slice (
      .clk        (clk),
      .rst        (rst),
      .en         (cnt_en),
      .inc        (INC_WIDTH'(perf_inc_slice(inc_vec_c, i, INC_WIDTH))),
      .clear      (clear),
      .capture    (capture_c),
      .cnt        (cnt[i]),
      .ovf        (ovf[i]),
      .shadow     (shadow[i]),
      .sovf       (sovf[i]),
      .ovf_next_c (ovf_next[i])
    );
  end

  // Dump sequencer; beat payload is loaded one cycle ahead so outputs are flops.
  always_comb begin
    state_d    = state_q;
    idx_d      = dump_idx;
    data_d     = dump_data;
    dovf_d     = dump_ovf;
    last_d     = dump_last;
    capture_c  = 1'b0;
    idx_next_c = dump_idx + PERF_IDX_W'(1);
    case (state_q)
      PERF_IDLE: begin
        if (snap_req) begin
          state_d   = PERF_DUMP;
          capture_c = 1'b1;
          idx_d     = '0;
          data_d    = cnt[0];
          dovf_d    = ovf[0];
          last_d    = 1'b0;
        end
      end
      PERF_DUMP: begin
        if (dump_ready) begin
          if (dump_last) begin
            state_d = PERF_IDLE;
            idx_d   = '0;
            last_d  = 1'b0;
          end else begin
            idx_d  = idx_next_c;
            data_d = shadow[idx_next_c];
            dovf_d = sovf[idx_next_c];
            last_d = (idx_next_c == LAST_IDX);
          end
        end
      end
      default: state_d = PERF_IDLE;
    endcase
    valid_d = (state_d == PERF_DUMP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PERF_IDLE;
      dump_idx   <= '0;
      dump_data  <= '0;
      dump_ovf   <= 1'b0;
      dump_last  <= 1'b0;
      dump_valid <= 1'b0;
      snap_busy  <= 1'b0;
      ovf_any    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dump_idx   <= idx_d;
      dump_data  <= data_d;
      dump_ovf   <= dovf_d;
      dump_last  <= last_d;
      dump_valid <= valid_d;
      snap_busy  <= valid_d;
      ovf_any    <= |ovf_next;
    end
  end

endmodule
